piso_nibble_sequencer: RTL and testbench
========================================

# piso_nibble_sequencer

Upstream controller for the 4-bit parallel-in/serial-out shift register. Accepts parallel sample words over a valid/ready handshake, double-buffers them, and drives the shift register's `load` and `data[3:0]` inputs nibble by nibble (MSB nibble first), so the register emits one continuous MSB-first serial bit per clock. Also produces a frame-sync strobe and bit-valid flag aligned to the shift register's serial output, and flags underrun.

## Interface
- `WORD_WIDTH`, default 16: sample word width; must be a multiple of 4 and at least 4. `NIB = WORD_WIDTH/4` nibbles per frame; frame length `WORD_WIDTH` clocks.
- `clock`  in  1  system clock; all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_word`  in  WORD_WIDTH  sample to serialize.
- `in_valid`  in  1  `in_word` is valid.
- `in_ready`  out  1  sequencer can accept a word; transfer occurs on an edge where `in_valid` and `in_ready` are both 1.
- `piso_load`  out  1  connects to the shift register's `load`; 1 = parallel load at next edge, 0 = shift.
- `piso_data`  out  4  connects to the shift register's `data[3:0]`.
- `frame_sync`  out  1  high for exactly one cycle, the cycle in which the serial output carries the word MSB.
- `bit_valid`  out  1  high in every cycle in which the serial output carries a word bit.
- `underrun`  out  1  one-cycle pulse when a frame finishes with no next word buffered.

## Operation
- Registers: `cur` (WORD_WIDTH), `nxt` (WORD_WIDTH), `nxt_v`, `active`, phase counter `ph` (log2 WORD_WIDTH bits), plus registered `frame_sync`, `bit_valid`, `underrun`.
- `in_ready = !nxt_v`. On accept: `nxt <= in_word`, `nxt_v <= 1`.
- IDLE (`active = 0`): if `nxt_v`, then `cur <= nxt`, `nxt_v <= 0`, `active <= 1`, `ph <= 0`.
- RUN (`active = 1`): `ph` increments each clock.
  - At `ph = WORD_WIDTH-1`: if `nxt_v`, reload `cur` from `nxt`, clear `nxt_v`, set `ph <= 0`, and stay in RUN (gapless). Otherwise set `active <= 0` and pulse `underrun` in the next cycle.
- Load and data while in RUN:
  - `piso_load = 1` when `ph[1:0] = 0`, else 0.
  - `piso_data = cur` nibble `(NIB-1 - ph/4)`, i.e. bits `[WORD_WIDTH-1-4k -: 4]` with `k = ph/4`.
  - `piso_data` is held constant for all 4 cycles of a nibble slot.
- IDLE drive: `piso_load = 1`, `piso_data = 0`. The shift register continuously reloads zero, so the serial line idles low.
- Flag registers:
  - `frame_sync <= active && ph = 0`.
  - `bit_valid <= active`.
  - `underrun <= active && ph = WORD_WIDTH-1 && !nxt_v`.
- Simultaneous accept and consume is impossible because `in_ready` is 0 whenever `nxt_v` is 1. A word arriving in the same cycle as the `ph = WORD_WIDTH-1` underrun decision is not used for that boundary: underrun fires, IDLE is entered, and the new frame starts from IDLE.
- Reset (asserted at any time, including mid-frame) clears `cur`, `nxt`, `nxt_v`, `active`, `ph` and all flags. The in-flight frame and buffered word are discarded.
  - Outputs during and after reset: `in_ready = 1`, `piso_load = 1`, `piso_data = 0`, `frame_sync = 0`, `bit_valid = 0`, `underrun = 0`.

## Timing
- The shift register captures `piso_load`/`piso_data` at the edge ending the cycle in which they are presented.
- Serial bit alignment: in the RUN cycle with phase `ph` (1..WORD_WIDTH-1), the serial output carries bit `WORD_WIDTH-ph`. Bit 0 appears in the cycle after `ph = WORD_WIDTH-1`, which is either the next frame's `ph = 0` or the first IDLE cycle.
- `frame_sync`/`bit_valid` are one cycle behind the `ph` they decode, so they line up exactly with the serial bits.
- Latency: word accepted at edge E0 → `nxt_v` at E0+ → RUN `ph = 0` after E1 → load at E2 → MSB on serial output and `frame_sync = 1` in the cycle after E2. That is 3 edges from acceptance.
- Throughput: one bit per clock. Back-to-back frames have zero gap provided the next word is accepted at least one cycle before the `ph = WORD_WIDTH-1` edge. `in_ready` re-asserts the cycle after consumption, leaving `WORD_WIDTH-1` cycles of margin.

## Test plan
- Reset mid-frame (WORD_WIDTH=16, word 0xA5C3 at `ph = 7`): on `reset_n` low, all outputs immediately take their reset values (`piso_load=1`, `piso_data=0`, `in_ready=1`). After release, the serial line stays 0 and `bit_valid` stays 0 until a new word arrives.
- Single word 0xA5C3 from idle: serial output is 1010 0101 1100 0011 on 16 consecutive cycles starting 3 edges after acceptance. `frame_sync` is high only on the first of those bits. `underrun` pulses once; the line then returns to 0.
- Back-to-back 0xFFFF then 0x0001, with the second word presented during the first frame: 32 contiguous bits, `bit_valid` high for 32 cycles with no gap, `frame_sync` high at cycles 0 and 16, no `underrun` between frames.
- Backpressure: hold `in_valid` with three words while a frame runs. `in_ready` is 0 while `nxt_v = 1`, each word is transferred exactly once, and all three frames come out in order with no gap.
- Late word: present the next word in the `ph = 15` cycle. `underrun` pulses, one idle-zero cycle carries bit 0 of the prior frame, and the new frame starts via IDLE with the same 3-edge latency.
- WORD_WIDTH=4, word 0x9: serial output 1,0,0,1. `piso_load` is high in every RUN cycle where `ph = 0`, and `frame_sync` is high every frame.

Source files
------------

// File: rtl/piso_nibble_sequencer.sv
// piso_nibble_sequencer
// Upstream controller for a 4-bit parallel-in/serial-out shift register.
// It accepts sample words over a valid/ready handshake and double-buffers
// them (one word serializing in cur, one waiting in nxt). It then drives the
// register's load/data pins one nibble at a time, MSB nibble first, so the
// register emits a continuous MSB-first bit stream. Frame-sync, bit-valid and
// underrun flags are registered one cycle behind the phase they decode. That
// extra cycle lines them up with the register's serial output.
module piso_nibble_sequencer #(
   parameter int WORD_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [WORD_WIDTH-1:0] in_word,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  piso_load,
   output logic [3:0]            piso_data,
   output logic                  frame_sync,
   output logic                  bit_valid,
   output logic                  underrun
);

   localparam int NIB = WORD_WIDTH / 4;
   localparam int PW  = $clog2(WORD_WIDTH);
   localparam logic [PW-1:0] PH_LAST = PW'(WORD_WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                state;
   logic [WORD_WIDTH-1:0] cur;
   logic [WORD_WIDTH-1:0] nxt;
   logic                  nxt_v;
   logic [PW-1:0]         ph;
   logic                  active;
   logic                  accept;
   logic [3:0]            cur_nibble;

   assign active   = (state == RUN);
   assign in_ready = ~nxt_v;
   assign accept   = in_valid & ~nxt_v;

   // Pick the nibble of cur for the current 4-cycle slot, MSB nibble first
   always_comb begin
      cur_nibble = 4'h0;
      for (int i = 0; i < NIB; i++) begin
         if ((int'(ph) >> 2) == i) begin
            cur_nibble = cur[WORD_WIDTH-1-4*i -: 4];
         end
      end
   end

   // Drive the shift register: load at each slot start while running, reload zero when idle
   always_comb begin
      piso_load = 1'b1;
      piso_data = 4'h0;
      if (active) begin
         piso_load = (ph[1:0] == 2'b00);
         piso_data = cur_nibble;
      end
   end

   // Sequencer state machine: buffer handshake, frame phase, gapless reload and aligned flags
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cur        <= '0;
         nxt        <= '0;
         nxt_v      <= 1'b0;
         ph         <= '0;
         frame_sync <= 1'b0;
         bit_valid  <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         frame_sync <= active && (ph == '0);
         bit_valid  <= active;
         underrun   <= active && (ph == PH_LAST) && !nxt_v;

         if (accept) begin
            nxt   <= in_word;
            nxt_v <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (nxt_v) begin
                  cur   <= nxt;
                  nxt_v <= 1'b0;
                  ph    <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (ph == PH_LAST) begin
                  ph <= '0;
                  if (nxt_v) begin
                     cur   <= nxt;
                     nxt_v <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  ph <= ph + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piso_nibble_sequencer.sv
// tb_piso_nibble_sequencer
// Drives a 16-bit sequencer with directed and random traffic. A model of the
// external 4-bit shift register reconstructs the serial line. The reference
// model predicts each frame's start cycle from handshake times. From those
// start times it derives the expected bit stream and the flags.
// A second 4-bit-wide instance covers the one-nibble frame case.
module tb_piso_nibble_sequencer;

   localparam int WW = 16;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [WW-1:0] in_word;
   logic          in_valid;
   logic          in_ready;
   logic          piso_load;
   logic [3:0]    piso_data;
   logic          frame_sync;
   logic          bit_valid;
   logic          underrun;

   logic          reset4_n;
   logic [3:0]    in_word4;
   logic          in_valid4;
   logic          in_ready4;
   logic          piso_load4;
   logic [3:0]    piso_data4;
   logic          frame_sync4;
   logic          bit_valid4;
   logic          underrun4;

   logic [3:0]    sr  = 4'h0;
   logic [3:0]    sr4 = 4'h0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic lastFire = 1'b0;

   typedef struct {
      logic [WW-1:0] word;
      int            acc;
      int            start;
   } frame_t;

   frame_t frames[$];

   piso_nibble_sequencer #(.WORD_WIDTH(WW)) u_dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_word    (in_word),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .piso_load  (piso_load),
      .piso_data  (piso_data),
      .frame_sync (frame_sync),
      .bit_valid  (bit_valid),
      .underrun   (underrun)
   );

   piso_nibble_sequencer #(.WORD_WIDTH(4)) u_dut4 (
      .clock      (clock),
      .reset_n    (reset4_n),
      .in_word    (in_word4),
      .in_valid   (in_valid4),
      .in_ready   (in_ready4),
      .piso_load  (piso_load4),
      .piso_data  (piso_data4),
      .frame_sync (frame_sync4),
      .bit_valid  (bit_valid4),
      .underrun   (underrun4)
   );

   // Free-running clock
   always #5 clock = ~clock;

   // Behavioural 4-bit PISO registers hanging off each sequencer
   always @(posedge clock) begin
      sr  <= piso_load  ? piso_data  : {sr[2:0], 1'b0};
      sr4 <= piso_load4 ? piso_data4 : {sr4[2:0], 1'b0};
   end

   // Watchdog so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   // A frame with phase-0 cycle s carries its bits in cycles s+1 .. s+WW.
   function automatic void modelAt(input int c, output logic bv, output logic fs, output logic ur,
                                   output logic ser, output logic rdy, output logic run);
      bv = 0; fs = 0; ur = 0; ser = 0; rdy = 1; run = 0;
      foreach (frames[i]) begin
         if (c > frames[i].start && c <= frames[i].start + WW) begin
            bv  = 1;
            ser = frames[i].word[WW - (c - frames[i].start)];
            if (c == frames[i].start + 1) fs = 1;
         end
         if (c >= frames[i].start && c < frames[i].start + WW) run = 1;
         if (c >= frames[i].acc && c < frames[i].start) rdy = 0;
         if (c == frames[i].start + WW) ur = 1;
      end
      foreach (frames[i]) begin
         if (frames[i].start == c) ur = 0;
      end
   endfunction

   function automatic logic modelReady(input int c);
      logic bv, fs, ur, ser, rdy, run;
      modelAt(c, bv, fs, ur, ser, rdy, run);
      return rdy;
   endfunction

   // A word taken at edge e follows gaplessly if it arrived before the previous frame's last phase
   function automatic void acceptWord(input logic [WW-1:0] w, input int e);
      frame_t f;
      f.word = w;
      f.acc  = e;
      if (frames.size() > 0 && e <= frames[$].start + WW - 1) f.start = frames[$].start + WW;
      else f.start = e + 1;
      frames.push_back(f);
   endfunction

   task automatic checkCycle();
      logic bv, fs, ur, ser, rdy, run;
      if (!reset_n) begin
         checkOutput("rst_in_ready",   in_ready,   1);
         checkOutput("rst_piso_load",  piso_load,  1);
         checkOutput("rst_piso_data",  piso_data,  0);
         checkOutput("rst_frame_sync", frame_sync, 0);
         checkOutput("rst_bit_valid",  bit_valid,  0);
         checkOutput("rst_underrun",   underrun,   0);
      end else begin
         modelAt(cyc, bv, fs, ur, ser, rdy, run);
         checkOutput("serial",     sr[3],      ser);
         checkOutput("bit_valid",  bit_valid,  bv);
         checkOutput("frame_sync", frame_sync, fs);
         checkOutput("underrun",   underrun,   ur);
         checkOutput("in_ready",   in_ready,   rdy);
         if (!run) begin
            checkOutput("idle_load", piso_load, 1);
            checkOutput("idle_data", piso_data, 0);
         end
      end
   endtask

   task automatic stepCycle();
      logic fire;
      @(negedge clock);
      checkCycle();
      fire = in_valid && reset_n && modelReady(cyc);
      @(posedge clock);
      cyc++;
      if (fire) acceptWord(in_word, cyc);
      lastFire = fire;
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [WW-1:0] w);
      in_valid = v;
      in_word  = w;
      stepCycle();
   endtask

   task automatic idleCycles(input int n);
      repeat (n) applyStimulus(1'b0, in_word);
   endtask

   task automatic sendWord(input logic [WW-1:0] w);
      int n = 0;
      in_valid = 1'b1;
      in_word  = w;
      do begin
         stepCycle();
         n++;
      end while (!lastFire && n < 200);
      if (!lastFire) checkOutput("handshake_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic waitUntilCycle(input int target);
      int n = 0;
      while (cyc < target && n < 200) begin
         idleCycles(1);
         n++;
      end
   endtask

   initial begin
      int pct;
      int urCount;
      int s;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_word   = '0;
      reset4_n  = 1'b0;
      in_valid4 = 1'b0;
      in_word4  = 4'h0;

      // Reset state, then release
      repeat (3) stepCycle();
      reset_n = 1'b1;
      idleCycles(4);

      // Single word from idle
      sendWord(16'hA5C3);
      idleCycles(24);

      // Back-to-back, second word offered during the first frame
      sendWord(16'hFFFF);
      idleCycles(3);
      sendWord(16'h0001);
      idleCycles(40);

      // Backpressure: valid held across three words
      sendWord(16'h1357);
      sendWord(16'h9BDF);
      sendWord(16'h2468);
      idleCycles(60);

      // Late word offered exactly in the last-phase cycle
      sendWord(16'h1234);
      s = frames[$].start;
      waitUntilCycle(s + 15);
      applyStimulus(1'b1, 16'hBEEF);
      in_valid = 1'b0;
      idleCycles(24);

      // Reset in the middle of a frame
      sendWord(16'hA5C3);
      s = frames[$].start;
      waitUntilCycle(s + 7);
      reset_n = 1'b0;
      frames.delete();
      #1;
      checkCycle();
      repeat (3) stepCycle();
      reset_n = 1'b1;
      idleCycles(20);

      // Random traffic with varying offered load
      for (int p = 0; p < 10; p++) begin
         pct = $urandom_range(100, 5);
         for (int i = 0; i < 250; i++) begin
            if (!(in_valid && !lastFire)) begin
               in_valid = ($urandom_range(99, 0) < pct);
               in_word  = WW'($urandom);
            end
            stepCycle();
         end
      end
      in_valid = 1'b0;
      idleCycles(40);

      // One-nibble frames: 0x9 offered continuously
      in_valid4 = 1'b1;
      in_word4  = 4'h9;
      @(posedge clock);
      #1;
      reset4_n = 1'b1;
      for (int j = 1; j <= 16; j++) begin
         @(posedge clock);
         @(negedge clock);
         if (j < 3) begin
            checkOutput("w4_serial_pre", sr4[3], 0);
            checkOutput("w4_bv_pre", bit_valid4, 0);
         end else begin
            checkOutput("w4_serial", sr4[3], in_word4[3 - ((j - 3) % 4)]);
            checkOutput("w4_bv", bit_valid4, 1);
            checkOutput("w4_frame_sync", frame_sync4, ((j - 3) % 4) == 0);
         end
         if (j >= 2) checkOutput("w4_load", piso_load4, ((j - 2) % 4) == 0);
         if (j == 1) checkOutput("w4_in_ready", in_ready4, 0);
         checkOutput("w4_underrun", underrun4, 0);
      end
      in_valid4 = 1'b0;
      urCount = 0;
      repeat (24) begin
         @(negedge clock);
         if (underrun4) urCount++;
      end
      checkOutput("w4_underrun_count", urCount, 1);
      checkOutput("w4_bv_end", bit_valid4, 0);
      checkOutput("w4_serial_end", sr4[3], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
